controle_requisicoes: RTL and testbench

Command sequencer between the UART pair and the DHT11 reader in the FPGA top level. It collects a two-byte request from `uart_rx`, validates it, starts a sensor read when one is needed, and returns a two-byte response through `uart_tx`. It also owns continuous-measurement mode and all timeouts. It is the only block that drives `uart_tx` start and the DHT11 reader start.

---
 rtl/controle_requisicoes.sv | 265 ++++++++++++++++++++++++++
 tb/tb_controle_requisicoes.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_requisicoes.sv
// Request sequencer between the UART pair and the DHT11 reader: collects a two-byte
// request, starts sensor reads, returns a two-byte response and runs continuous mode.
module controle_requisicoes #(
   parameter int unsigned TIMEOUT_CICLOS   = 50_000_000,
   parameter int unsigned PERIODO_CONTINUO = 100_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxValido,
   input  logic [7:0] rxByte,
   input  logic       txOcupado,
   output logic       txIniciar,
   output logic [7:0] txByte,
   output logic       sensorIniciar,
   input  logic       sensorPronto,
   input  logic       sensorErro,
   input  logic [7:0] umidade,
   input  logic [7:0] temperatura,
   output logic       ocupado,
   output logic [1:0] modoContinuo
);

   localparam int unsigned TmoW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam int unsigned PerW = (PERIODO_CONTINUO > 2) ? $clog2(PERIODO_CONTINUO) : 1;
   localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CICLOS - 1);
   localparam logic [PerW-1:0] PerMax = PerW'(PERIODO_CONTINUO - 1);

   typedef enum logic [3:0] {
      StEsperaCmd,
      StEsperaEnd,
      StDecodifica,
      StDisparaSensor,
      StAguardaSensor,
      StEnviaB0,
      StAguardaTx0,
      StEnviaB1,
      StAguardaTx1
   } estado_e;

   estado_e         estado_q, estado_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      end_q, end_d;
   logic [7:0]      codigo_q, codigo_d;
   logic [7:0]      dado_q, dado_d;
   logic [1:0]      modo_q, modo_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [PerW-1:0] per_q, per_d;
   logic            pend_q, pend_d;
   logic            tx_primeiro_q, tx_primeiro_d;

   logic expira;
   logic tmo_fim;
   logic dispara_auto;

   assign expira       = (modo_q != 2'b00) && (per_q == PerMax);
   assign tmo_fim      = (tmo_q == TmoMax);
   assign dispara_auto = (estado_q == StEsperaCmd) && !rxValido && (expira || pend_q);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= StEsperaCmd;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Next-state logic
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         StEsperaCmd: begin
            if (rxValido) begin
               estado_d = StEsperaEnd;
            end else if (expira || pend_q) begin
               estado_d = StDisparaSensor;
            end
         end
         StEsperaEnd: begin
            if (rxValido) begin
               estado_d = StDecodifica;
            end else if (tmo_fim) begin
               estado_d = StEsperaCmd;
            end
         end
         StDecodifica: begin
            if ((cmd_q <= 8'h02) && (end_q == 8'h00)) begin
               estado_d = StDisparaSensor;
            end else begin
               estado_d = StEnviaB0;
            end
         end
         StDisparaSensor: estado_d = StAguardaSensor;
         StAguardaSensor: begin
            if (sensorPronto || tmo_fim) begin
               estado_d = StEnviaB0;
            end
         end
         StEnviaB0: begin
            if (!txOcupado) begin
               estado_d = StAguardaTx0;
            end
         end
         StAguardaTx0: begin
            if (!tx_primeiro_q && !txOcupado) begin
               estado_d = StEnviaB1;
            end
         end
         StEnviaB1: begin
            if (!txOcupado) begin
               estado_d = StAguardaTx1;
            end
         end
         StAguardaTx1: begin
            if (!tx_primeiro_q && !txOcupado) begin
               estado_d = StEsperaCmd;
            end
         end
         default: estado_d = StEsperaCmd;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cmd_q         <= 8'h00;
         end_q         <= 8'h00;
         codigo_q      <= 8'h00;
         dado_q        <= 8'h00;
         modo_q        <= 2'b00;
         tmo_q         <= '0;
         per_q         <= '0;
         pend_q        <= 1'b0;
         tx_primeiro_q <= 1'b0;
      end else begin
         cmd_q         <= cmd_d;
         end_q         <= end_d;
         codigo_q      <= codigo_d;
         dado_q        <= dado_d;
         modo_q        <= modo_d;
         tmo_q         <= tmo_d;
         per_q         <= per_d;
         pend_q        <= pend_d;
         tx_primeiro_q <= tx_primeiro_d;
      end
   end

   always_comb begin
      cmd_d    = cmd_q;
      end_d    = end_q;
      codigo_d = codigo_q;
      dado_d   = dado_q;
      modo_d   = modo_q;
      pend_d   = pend_q;

      // Timeout count restarts whenever a waiting state is entered
      tmo_d = tmo_q;
      if ((estado_q == StEsperaEnd) || (estado_q == StAguardaSensor)) begin
         tmo_d = tmo_q + TmoW'(1);
      end
      if (((estado_d == StEsperaEnd) && (estado_q != StEsperaEnd)) ||
          ((estado_d == StAguardaSensor) && (estado_q != StAguardaSensor))) begin
         tmo_d = '0;
      end

      tx_primeiro_d = ((estado_q == StEnviaB0) || (estado_q == StEnviaB1)) && !txOcupado;

      if (modo_q == 2'b00 || per_q == PerMax) begin
         per_d = '0;
      end else begin
         per_d = per_q + PerW'(1);
      end

      case (estado_q)
         StEsperaCmd: begin
            if (rxValido) begin
               cmd_d = rxByte;
            end else if (expira || pend_q) begin
               cmd_d = (modo_q == 2'b01) ? 8'h01 : 8'h02;
               end_d = 8'h00;
            end
         end
         StEsperaEnd: begin
            if (rxValido) begin
               end_d = rxByte;
            end
         end
         StDecodifica: begin
            dado_d = 8'h00;
            if (cmd_q > 8'h05) begin
               codigo_d = 8'hEF;
            end else if (end_q != 8'h00) begin
               codigo_d = 8'hDF;
            end else begin
               case (cmd_q)
                  8'h03: begin
                     modo_d   = 2'b01;
                     codigo_d = 8'h0C;
                  end
                  8'h04: begin
                     modo_d   = 2'b10;
                     codigo_d = 8'h0D;
                  end
                  8'h05: begin
                     modo_d   = 2'b00;
                     codigo_d = 8'h0A;
                  end
                  default: codigo_d = codigo_q;
               endcase
            end
         end
         StAguardaSensor: begin
            if (sensorPronto) begin
               if (sensorErro) begin
                  codigo_d = 8'h1F;
                  dado_d   = 8'h00;
               end else begin
                  case (cmd_q)
                     8'h01: begin
                        codigo_d = 8'h09;
                        dado_d   = temperatura;
                     end
                     8'h02: begin
                        codigo_d = 8'h08;
                        dado_d   = umidade;
                     end
                     default: begin
                        codigo_d = 8'h00;
                        dado_d   = 8'h00;
                     end
                  endcase
               end
            end else if (tmo_fim) begin
               codigo_d = 8'h1F;
               dado_d   = 8'h00;
            end
         end
         default: ;
      endcase

      // An expiry not consumed right away is remembered until the block is idle again
      if (expira && !dispara_auto) begin
         pend_d = 1'b1;
      end else if (dispara_auto) begin
         pend_d = 1'b0;
      end
      if (modo_d == 2'b00) begin
         pend_d = 1'b0;
      end
   end

   // Outputs
   always_comb begin
      txIniciar     = ((estado_q == StEnviaB0) || (estado_q == StEnviaB1)) && !txOcupado;
      sensorIniciar = (estado_q == StDisparaSensor);
      ocupado       = (estado_q != StEsperaCmd);
      modoContinuo  = modo_q;
      case (estado_q)
         StEnviaB0, StAguardaTx0: txByte = codigo_q;
         StEnviaB1, StAguardaTx1: txByte = dado_q;
         default:                 txByte = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_controle_requisicoes.sv
// Randomized bench for controle_requisicoes: a request-level reference model pushes
// expected responses into a queue that a monitor checks against every transmitted byte.
module tb_controle_requisicoes;

   localparam int unsigned Tmo = 100;
   localparam int unsigned Per = 1000;

   logic       clock = 1'b0;
   logic       reset;
   logic       rxValido;
   logic [7:0] rxByte;
   logic       txOcupado;
   logic       txIniciar;
   logic [7:0] txByte;
   logic       sensorIniciar;
   logic       sensorPronto;
   logic       sensorErro;
   logic [7:0] umidade;
   logic [7:0] temperatura;
   logic       ocupado;
   logic [1:0] modoContinuo;

   controle_requisicoes #(
      .TIMEOUT_CICLOS  (Tmo),
      .PERIODO_CONTINUO(Per)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .rxValido     (rxValido),
      .rxByte       (rxByte),
      .txOcupado    (txOcupado),
      .txIniciar    (txIniciar),
      .txByte       (txByte),
      .sensorIniciar(sensorIniciar),
      .sensorPronto (sensorPronto),
      .sensorErro   (sensorErro),
      .umidade      (umidade),
      .temperatura  (temperatura),
      .ocupado      (ocupado),
      .modoContinuo (modoContinuo)
   );

   always #5 clock = ~clock;

   int unsigned ciclo = 0;
   always @(posedge clock) ciclo <= ciclo + 1;

   int          vetores = 0;
   int          erros = 0;
   logic [15:0] esperado_q[$];
   logic [7:0]  sen_temp = 8'h00;
   logic [7:0]  sen_umid = 8'h00;
   logic        sen_erro = 1'b0;
   logic        sen_mudo = 1'b0;
   int          sen_atraso = 5;
   int          leituras_req = 0;
   int          n_auto = 0;
   int          tx_count = 0;
   int          modo_modelo = 0;
   int unsigned t_auto = 0;
   bit          verifica_periodo = 1'b0;

   task automatic checa(input string nome, input logic [31:0] atual, input logic [31:0] req);
      vetores++;
      if (atual !== req) begin
         erros++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nome, atual, req, ciclo);
      end
   endtask

   // Response the specification prescribes for one request
   function automatic logic [15:0] resposta(input logic [7:0] cmd, input logic [7:0] adr,
                                            input logic erro, input logic mudo,
                                            input logic [7:0] temp, input logic [7:0] umid);
      if (cmd > 8'h05) return 16'hEF00;
      if (adr != 8'h00) return 16'hDF00;
      if (cmd <= 8'h02 && (erro || mudo)) return 16'h1F00;
      case (cmd)
         8'h00:   return 16'h0000;
         8'h01:   return {8'h09, temp};
         8'h02:   return {8'h08, umid};
         8'h03:   return 16'h0C00;
         8'h04:   return 16'h0D00;
         default: return 16'h0A00;
      endcase
   endfunction

   // UART transmitter model
   initial begin
      txOcupado = 1'b0;
      forever begin
         @(negedge clock);
         if (txIniciar && !reset) begin
            @(posedge clock);
            #1 txOcupado = 1'b1;
            repeat ($urandom_range(6, 18)) @(posedge clock);
            #1 txOcupado = 1'b0;
         end
      end
   end

   // Scoreboard monitor
   initial begin
      int          idx = 0;
      logic [7:0]  b_atual = 8'h00;
      bit          estab = 1'b0;
      logic [15:0] f;
      forever begin
         @(negedge clock);
         if (reset) begin
            idx   = 0;
            estab = 1'b0;
         end else if (txIniciar) begin
            tx_count++;
            if (esperado_q.size() == 0) begin
               vetores++;
               erros++;
               $display("FAIL tx_inesperado: byte %02h sent, nothing expected (cycle %0d)",
                        txByte, ciclo);
            end else if (idx == 0) begin
               f = esperado_q[0];
               checa("byte0", {24'h0, txByte}, {24'h0, f[15:8]});
               idx = 1;
            end else begin
               f = esperado_q.pop_front();
               checa("byte1", {24'h0, txByte}, {24'h0, f[7:0]});
               idx = 0;
            end
            b_atual = txByte;
            estab   = 1'b1;
         end else if (estab && txOcupado) begin
            checa("txByte_estavel", {24'h0, txByte}, {24'h0, b_atual});
         end else if (!txOcupado) begin
            estab = 1'b0;
         end
      end
   end

   // DHT11 reader model; automatic reads get their expected response here
   initial begin
      sensorPronto = 1'b0;
      sensorErro   = 1'b0;
      temperatura  = 8'h00;
      umidade      = 8'h00;
      forever begin
         @(negedge clock);
         if (sensorIniciar && !reset) begin
            if (leituras_req > 0) begin
               leituras_req--;
            end else begin
               if (modo_modelo == 0) begin
                  vetores++;
                  erros++;
                  $display("FAIL leitura_inesperada: sensorIniciar with mode off (cycle %0d)",
                           ciclo);
               end else begin
                  esperado_q.push_back(resposta((modo_modelo == 1) ? 8'h01 : 8'h02, 8'h00,
                                                sen_erro, sen_mudo, sen_temp, sen_umid));
               end
               if (verifica_periodo && t_auto != 0) checa("periodo", ciclo - t_auto, Per);
               t_auto = ciclo;
               n_auto++;
            end
            if (sen_mudo) begin
               int k;
               for (k = 1; k < 300; k++) begin
                  @(posedge clock);
                  #1;
                  if (txIniciar) break;
               end
               checa("ciclos_timeout_sensor", k, Tmo + 1);
            end else begin
               repeat (sen_atraso) @(posedge clock);
               #1;
               sensorPronto = 1'b1;
               sensorErro   = sen_erro;
               temperatura  = sen_temp;
               umidade      = sen_umid;
               @(posedge clock);
               #1;
               sensorPronto = 1'b0;
               sensorErro   = $urandom_range(0, 1);
               temperatura  = 8'($urandom);
               umidade      = 8'($urandom);
               checa("tx_apos_pronto", {31'h0, txIniciar}, 32'h1);
            end
         end
      end
   end

   task automatic espera_livre();
      for (int k = 0; k < 3000; k++) begin
         @(negedge clock);
         if (!ocupado) break;
      end
   endtask

   task automatic requisicao(input logic [7:0] cmd, input logic [7:0] adr, input logic erro,
                             input logic mudo, input logic [7:0] temp, input logic [7:0] umid,
                             input int atraso);
      bit le;
      le         = (cmd <= 8'h02) && (adr == 8'h00);
      sen_erro   = erro;
      sen_mudo   = mudo;
      sen_temp   = temp;
      sen_umid   = umid;
      sen_atraso = atraso;
      esperado_q.push_back(resposta(cmd, adr, erro, mudo, temp, umid));
      if (le) leituras_req++;
      if (adr == 8'h00 && cmd == 8'h03) modo_modelo = 1;
      if (adr == 8'h00 && cmd == 8'h04) modo_modelo = 2;
      if (adr == 8'h00 && cmd == 8'h05) modo_modelo = 0;
      @(posedge clock);
      #1 rxValido = 1'b1;
      rxByte = cmd;
      @(posedge clock);
      #1 rxValido = 1'b0;
      rxByte = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(posedge clock);
      #1 rxValido = 1'b1;
      rxByte = adr;
      @(posedge clock);
      #1 rxValido = 1'b0;
      @(posedge clock);
      #1;
      if (le) checa("sensorIniciar_N2", {31'h0, sensorIniciar}, 32'h1);
      else checa("txIniciar_N2", {31'h0, txIniciar}, 32'h1);
      if (le) begin
         // Byte arriving mid-transaction must be dropped
         @(posedge clock);
         #1 rxValido = 1'b1;
         rxByte = 8'($urandom);
         @(posedge clock);
         #1 rxValido = 1'b0;
      end
      espera_livre();
      checa("ocupado_fim", {31'h0, ocupado}, 32'h0);
      checa("txOcupado_no_fim", {31'h0, txOcupado}, 32'h0);
      checa("fila_vazia", esperado_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", ciclo);
      $fatal(1, "watchdog");
   end

   initial begin
      int alvo;
      int antes;
      logic [7:0] c;
      logic [7:0] a;
      reset    = 1'b1;
      rxValido = 1'b0;
      rxByte   = 8'h00;
      repeat (4) @(posedge clock);
      @(negedge clock);
      checa("reset_txIniciar", {31'h0, txIniciar}, 32'h0);
      checa("reset_sensorIniciar", {31'h0, sensorIniciar}, 32'h0);
      checa("reset_ocupado", {31'h0, ocupado}, 32'h0);
      checa("reset_txByte", {24'h0, txByte}, 32'h0);
      checa("reset_modo", {30'h0, modoContinuo}, 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;

      requisicao(8'h01, 8'h00, 1'b0, 1'b0, 8'h19, 8'h33, 90);
      requisicao(8'h07, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 5);
      requisicao(8'h02, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 5);
      requisicao(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 5);

      // Lone first byte: request is abandoned after exactly Tmo cycles
      @(posedge clock);
      #1 rxValido = 1'b1;
      rxByte = 8'h03;
      @(posedge clock);
      #1 rxValido = 1'b0;
      repeat (Tmo - 1) @(posedge clock);
      #1 checa("espera_end_antes_timeout", {31'h0, ocupado}, 32'h1);
      @(posedge clock);
      #1 checa("espera_end_timeout", {31'h0, ocupado}, 32'h0);
      checa("modo_sem_cmd", {30'h0, modoContinuo}, 32'h0);
      requisicao(8'h02, 8'h00, 1'b0, 1'b0, 8'h11, 8'h47, 20);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0: c = 8'h00;
            1, 2: c = 8'h01;
            3, 4: c = 8'h02;
            5: c = 8'h05;
            default: c = 8'($urandom_range(6, 255));
         endcase
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         requisicao(c, a, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    8'($urandom), 8'($urandom), $urandom_range(1, 60));
      end

      // Continuous humidity mode
      requisicao(8'h04, 8'h00, 1'b0, 1'b0, 8'h1A, 8'h3C, 12);
      checa("modo_umidade", {30'h0, modoContinuo}, 32'h2);
      verifica_periodo = 1'b1;
      alvo = n_auto + 3;
      for (int k = 0; k < 5000 && n_auto < alvo; k++) @(posedge clock);
      checa("leituras_automaticas", n_auto, alvo);
      verifica_periodo = 1'b0;
      espera_livre();
      // Request lands on the expiry cycle: it is served first, then the pending read
      alvo = int'(t_auto) + Per - 1;
      while (int'(ciclo) < alvo - 1) begin
         @(posedge clock);
         #1;
      end
      antes = n_auto;
      requisicao(8'h01, 8'h00, 1'b0, 1'b0, 8'h21, 8'h3C, 15);
      for (int k = 0; k < 500 && n_auto == antes; k++) @(posedge clock);
      checa("leitura_pendente", n_auto, antes + 1);
      espera_livre();
      requisicao(8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 5);
      checa("modo_desligado", {30'h0, modoContinuo}, 32'h0);
      antes = n_auto;
      repeat (2500) @(posedge clock);
      checa("sem_auto_apos_05", n_auto, antes);

      // Reset while waiting for byte 0 to finish
      sen_erro = 1'b0;
      sen_mudo = 1'b0;
      sen_temp = 8'h2B;
      sen_atraso = 10;
      esperado_q.push_back(resposta(8'h01, 8'h00, 1'b0, 1'b0, 8'h2B, 8'h00));
      leituras_req++;
      @(posedge clock);
      #1 rxValido = 1'b1;
      rxByte = 8'h01;
      @(posedge clock);
      #1 rxByte = 8'h00;
      @(posedge clock);
      #1 rxValido = 1'b0;
      for (int k = 0; k < 500 && !txOcupado; k++) @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      checa("rst_meio_txIniciar", {31'h0, txIniciar}, 32'h0);
      checa("rst_meio_sensorIniciar", {31'h0, sensorIniciar}, 32'h0);
      checa("rst_meio_ocupado", {31'h0, ocupado}, 32'h0);
      checa("rst_meio_txByte", {24'h0, txByte}, 32'h0);
      esperado_q.delete();
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      antes = tx_count;
      repeat (60) @(posedge clock);
      checa("sem_byte_obsoleto", tx_count - antes, 0);
      requisicao(8'h01, 8'h00, 1'b0, 1'b0, 8'h17, 8'h40, 30);

      $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
      $finish;
   end

endmodule
